// File: rtl/ppwa_poll_sequencer.sv
// AXI4-Lite master that configures the ppwa device once, then periodically
// sweeps every channel's period/high registers onto a valid/ready stream.
module ppwa_poll_sequencer #(
    parameter int NOF_CHANNELS = 4,
    parameter int ADDR_WIDTH   = 8,
    parameter int CFG_ADDR     = 'h00,
    parameter int BASE_ADDR    = 'h20,
    parameter int POLL_DIV     = 1000,
    parameter int TIMEOUT      = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [31:0]           cfg_value,
    output logic [ADDR_WIDTH-1:0] m_awaddr,
    output logic                  m_awvalid,
    input  logic                  m_awready,
    output logic [31:0]           m_wdata,
    output logic [3:0]            m_wstrb,
    output logic                  m_wvalid,
    input  logic                  m_wready,
    input  logic [1:0]            m_bresp,
    input  logic                  m_bvalid,
    output logic                  m_bready,
    output logic [ADDR_WIDTH-1:0] m_araddr,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    input  logic [31:0]           m_rdata,
    input  logic [1:0]            m_rresp,
    input  logic                  m_rvalid,
    output logic                  m_rready,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [3:0]            res_ch,
    output logic [31:0]           res_period,
    output logic [31:0]           res_high,
    output logic                  sweep_done,
    output logic                  err
);

    typedef enum logic [2:0] {
        S_IDLE, S_CFG_WR, S_CFG_B, S_RD_AR,
        S_RD_R, S_OUT, S_WAIT, S_ERR
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [ADDR_WIDTH-1:0] r_araddr;
    logic [31:0]           r_wdata;
    logic [31:0]           r_period;
    logic [31:0]           r_high;
    logic [31:0]           r_timer;
    logic [31:0]           r_tmo;
    logic [3:0]            r_ch;
    logic                  r_sub;
    logic                  r_awvalid;
    logic                  r_wvalid;
    logic                  r_bready;
    logic                  r_arvalid;
    logic                  r_rready;
    logic                  r_res_valid;
    logic                  r_sweep_done;
    logic                  r_err;

    logic w_aw_done;
    logic w_w_done;
    logic w_tmo;
    logic w_last;
    logic w_fail;

    function automatic logic [ADDR_WIDTH-1:0] f_addr(
        input logic [3:0] ch,
        input logic       sub
    );
        return ADDR_WIDTH'(BASE_ADDR + 8 * int'(ch) + (sub ? 4 : 0));
    endfunction

    assign w_aw_done = !r_awvalid || m_awready;
    assign w_w_done  = !r_wvalid || m_wready;
    assign w_tmo     = (r_tmo == 32'(TIMEOUT - 1));
    assign w_last    = (int'(r_ch) == NOF_CHANNELS - 1);

    // Error exits: bad response or a handshake that never arrives
    always_comb begin
        w_fail = 1'b0;
        unique case (r_state)
            S_CFG_WR: w_fail = !(w_aw_done && w_w_done) && w_tmo;
            S_CFG_B:  w_fail = m_bvalid ? (m_bresp != 2'b00) : w_tmo;
            S_RD_AR:  w_fail = !m_arready && w_tmo;
            S_RD_R:   w_fail = m_rvalid ? (m_rresp != 2'b00) : w_tmo;
            default:  w_fail = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_awaddr     <= '0;
            r_araddr     <= '0;
            r_wdata      <= '0;
            r_period     <= '0;
            r_high       <= '0;
            r_timer      <= '0;
            r_tmo        <= '0;
            r_ch         <= '0;
            r_sub        <= 1'b0;
            r_awvalid    <= 1'b0;
            r_wvalid     <= 1'b0;
            r_bready     <= 1'b0;
            r_arvalid    <= 1'b0;
            r_rready     <= 1'b0;
            r_res_valid  <= 1'b0;
            r_sweep_done <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_sweep_done <= 1'b0;
            if (w_fail) begin
                r_awvalid   <= 1'b0;
                r_wvalid    <= 1'b0;
                r_bready    <= 1'b0;
                r_arvalid   <= 1'b0;
                r_rready    <= 1'b0;
                r_res_valid <= 1'b0;
                r_err       <= 1'b1;
                r_state     <= S_ERR;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        if (enable) begin
                            r_awaddr  <= ADDR_WIDTH'(CFG_ADDR);
                            r_wdata   <= cfg_value;
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_tmo     <= '0;
                            r_state   <= S_CFG_WR;
                        end
                    end
                    S_CFG_WR: begin
                        if (m_awready) r_awvalid <= 1'b0;
                        if (m_wready)  r_wvalid  <= 1'b0;
                        if (w_aw_done && w_w_done) begin
                            r_bready <= 1'b1;
                            r_tmo    <= '0;
                            r_state  <= S_CFG_B;
                        end else begin
                            r_tmo <= r_tmo + 32'd1;
                        end
                    end
                    S_CFG_B: begin
                        if (m_bvalid) begin
                            r_bready  <= 1'b0;
                            r_ch      <= '0;
                            r_sub     <= 1'b0;
                            r_araddr  <= f_addr(4'd0, 1'b0);
                            r_arvalid <= 1'b1;
                            r_tmo     <= '0;
                            r_state   <= S_RD_AR;
                        end else begin
                            r_tmo <= r_tmo + 32'd1;
                        end
                    end
                    S_RD_AR: begin
                        if (m_arready) begin
                            r_arvalid <= 1'b0;
                            r_rready  <= 1'b1;
                            r_tmo     <= '0;
                            r_state   <= S_RD_R;
                        end else begin
                            r_tmo <= r_tmo + 32'd1;
                        end
                    end
                    S_RD_R: begin
                        if (m_rvalid) begin
                            r_rready <= 1'b0;
                            if (!r_sub) begin
                                r_period  <= m_rdata;
                                r_sub     <= 1'b1;
                                r_araddr  <= f_addr(r_ch, 1'b1);
                                r_arvalid <= 1'b1;
                                r_tmo     <= '0;
                                r_state   <= S_RD_AR;
                            end else begin
                                r_high      <= m_rdata;
                                r_res_valid <= 1'b1;
                                r_state     <= S_OUT;
                            end
                        end else begin
                            r_tmo <= r_tmo + 32'd1;
                        end
                    end
                    S_OUT: begin
                        if (res_ready) begin
                            r_res_valid <= 1'b0;
                            if (!w_last) begin
                                r_ch      <= r_ch + 4'd1;
                                r_sub     <= 1'b0;
                                r_araddr  <= f_addr(r_ch + 4'd1, 1'b0);
                                r_arvalid <= 1'b1;
                                r_tmo     <= '0;
                                r_state   <= S_RD_AR;
                            end else begin
                                r_sweep_done <= 1'b1;
                                if (enable) begin
                                    r_timer <= 32'(POLL_DIV - 1);
                                    r_state <= S_WAIT;
                                end else begin
                                    r_state <= S_IDLE;
                                end
                            end
                        end
                    end
                    S_WAIT: begin
                        if (!enable) begin
                            r_state <= S_IDLE;
                        end else if (r_timer == 32'd0) begin
                            r_ch      <= '0;
                            r_sub     <= 1'b0;
                            r_araddr  <= f_addr(4'd0, 1'b0);
                            r_arvalid <= 1'b1;
                            r_tmo     <= '0;
                            r_state   <= S_RD_AR;
                        end else begin
                            r_timer <= r_timer - 32'd1;
                        end
                    end
                    S_ERR: begin
                        r_err <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign m_awaddr   = r_awaddr;
    assign m_awvalid  = r_awvalid;
    assign m_wdata    = r_wdata;
    assign m_wstrb    = 4'hF;
    assign m_wvalid   = r_wvalid;
    assign m_bready   = r_bready;
    assign m_araddr   = r_araddr;
    assign m_arvalid  = r_arvalid;
    assign m_rready   = r_rready;
    assign res_valid  = r_res_valid;
    assign res_ch     = r_ch;
    assign res_period = r_period;
    assign res_high   = r_high;
    assign sweep_done = r_sweep_done;
    assign err        = r_err;

endmodule

// File: doc/ppwa_poll_sequencer.md
Name: ppwa_poll_sequencer

Overview:
AXI4-Lite master that sequences the ppwa device. On enable it writes one configuration word to the device. It then periodically sweeps every channel, reading the period and high-time registers. Each channel's result is presented on a valid/ready stream to the fabric, so the sequencer owns the device's slave port instead of a CPU or VIP master.

Parameters:
NOF_CHANNELS, 4, number of ppwa channels swept (1..16)
ADDR_WIDTH, 8, AXI address width
CFG_ADDR, 0x00, address of device config register
BASE_ADDR, 0x20, address of channel 0 period register; period(ch)=BASE_ADDR+8*ch, high(ch)=period(ch)+4
POLL_DIV, 1000, clock cycles from end of one sweep to start of next (>=1)
TIMEOUT, 255, max cycles waiting on any AXI handshake before error

Ports:
clk  in  1  system clock, all logic rising-edge
reset  in  1  synchronous, active-high reset
enable  in  1  level; high starts/continues polling, low stops after current sweep
cfg_value  in  32  word written to CFG_ADDR at start of polling
m_awaddr  out  ADDR_WIDTH  write address
m_awvalid  out  1  write address valid
m_awready  in  1  write address ready
m_wdata  out  32  write data
m_wstrb  out  4  write strobes, constant 0xF
m_wvalid  out  1  write data valid
m_wready  in  1  write data ready
m_bresp  in  2  write response
m_bvalid  in  1  write response valid
m_bready  out  1  write response ready
m_araddr  out  ADDR_WIDTH  read address
m_arvalid  out  1  read address valid
m_arready  in  1  read address ready
m_rdata  in  32  read data
m_rresp  in  2  read response
m_rvalid  in  1  read data valid
m_rready  out  1  read data ready
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
res_ch  out  4  channel index of result
res_period  out  32  period register value
res_high  out  32  high-time register value
sweep_done  out  1  one-cycle pulse after last channel result accepted
err  out  1  sticky; set on SLVERR/DECERR or timeout, cleared only by reset

Behaviour:
- Reset: all valid/ready outputs 0, all address/data outputs 0, sweep_done 0, err 0, state IDLE, channel counter 0, timer 0.
- States: IDLE, CFG_WR, CFG_B, RD_AR, RD_R, OUT, WAIT, ERR.
- IDLE: when enable=1, load m_awaddr=CFG_ADDR and m_wdata=cfg_value, assert m_awvalid and m_wvalid next cycle, go to CFG_WR.
- CFG_WR: awvalid and wvalid are dropped independently on their own handshakes. They may complete in the same or different cycles, in either order. When both are done, go to CFG_B with m_bready=1.
- CFG_B: on m_bvalid, drop bready. bresp!=0 -> ERR, else ch=0, sub=0, go to RD_AR.
- RD_AR: m_araddr=period(ch) if sub=0 else high(ch); arvalid held stable until m_arready, then RD_R with m_rready=1.
- RD_R: on m_rvalid, capture rdata into the period (sub=0) or high (sub=1) register and drop rready. rresp!=0 -> ERR. sub=0 -> sub=1, RD_AR. sub=1 -> OUT.
- At most one outstanding transaction; no VALID depends on READY.
- OUT: res_valid=1, and res_ch/res_period/res_high stay stable until res_ready. There is no timeout in OUT (backpressure stalls the sweep indefinitely). On the handshake:
  - ch<NOF_CHANNELS-1: ch++, sub=0, RD_AR.
  - otherwise: sweep_done pulses in the following cycle. enable=1 -> WAIT with timer=POLL_DIV-1; enable=0 -> IDLE.
- WAIT: timer decrements each cycle. enable=0 -> IDLE immediately. At timer=0, ch=0, RD_AR (config is not rewritten).
- Result latency (rready-sampled RD_R of high read to res_valid): 1 cycle.
- Timeout: counter reset on entry to CFG_WR/CFG_B/RD_AR/RD_R. If it reaches TIMEOUT before the pending handshake -> ERR, and all AXI valid/ready are deasserted that cycle.
- ERR: err=1, all outputs idle, terminal until reset.
- enable falling mid-sweep: the sweep completes, then IDLE. enable rising again restarts from config write.
- reset mid-transaction: returns to IDLE next cycle irrespective of the AXI state.

Test Plan:
- Zero-wait slave, NOF_CHANNELS=4, cfg_value=0x1, ch n period=0x100+n, high=0x80+n -> one write to 0x00 with data 0x1, then reads 0x20,0x24,0x28,...,0x3C. Results (0,0x100,0x80)...(3,0x103,0x83), then a sweep_done pulse.
- awready 3 cycles after wready, randomised arready/rvalid delays 0-5 -> identical results, valid signals stable until their handshake, single outstanding transaction.
- res_ready held low 50 cycles on channel 2 -> no new AR issued, res fields constant, then resume and complete the sweep.
- POLL_DIV=10 with enable held -> next sweep's first arvalid exactly 10 cycles after the sweep_done cycle. Dropping enable in WAIT -> IDLE, no AR issued.
- rresp=2'b10 on channel 1 high read -> err=1 and no further AXI activity. Separately, arready never asserted -> err=1 after 255 cycles.
- reset asserted during RD_R -> all outputs at reset values the next cycle. A subsequent enable restarts with the config write.
